// File: rtl/wbu_commit_if.sv
// EXU->WBU commit channel, GPR write port, CSR read port and IFU redirect channel of the write-back stage.
// master = EXU/IFU/regfile side, slave = wbu_commit.
interface wbu_commit_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] i_pc_next;
    logic [XLEN-1:0] i_res;
    logic [3:0]      i_rd_addr;
    logic            i_wen;
    logic            i_csr_wen;
    logic [11:0]     i_csr_addr;
    logic [XLEN-1:0] i_csr_wdata;
    logic            i_brch;
    logic            i_jal;
    logic            i_jalr;
    logic            i_ecall;
    logic            i_mret;
    logic            i_ebreak;
    logic [11:0]     i_csr_raddr;
    logic [XLEN-1:0] o_csr_rdata;
    logic            o_rf_wen;
    logic [3:0]      o_rf_waddr;
    logic [XLEN-1:0] o_rf_wdata;
    logic            o_pc_valid;
    logic [XLEN-1:0] o_pc_next;
    logic            i_pc_ready;
    logic            o_commit;
    logic [XLEN-1:0] o_commit_pc;
    logic            o_halt;

    modport master (
        output i_valid, i_pc, i_pc_next, i_res, i_rd_addr, i_wen,
               i_csr_wen, i_csr_addr, i_csr_wdata,
               i_brch, i_jal, i_jalr, i_ecall, i_mret, i_ebreak,
               i_csr_raddr, i_pc_ready,
        input  o_ready, o_csr_rdata, o_rf_wen, o_rf_waddr, o_rf_wdata,
               o_pc_valid, o_pc_next, o_commit, o_commit_pc, o_halt
    );

    modport slave (
        input  i_valid, i_pc, i_pc_next, i_res, i_rd_addr, i_wen,
               i_csr_wen, i_csr_addr, i_csr_wdata,
               i_brch, i_jal, i_jalr, i_ecall, i_mret, i_ebreak,
               i_csr_raddr, i_pc_ready,
        output o_ready, o_csr_rdata, o_rf_wen, o_rf_waddr, o_rf_wdata,
               o_pc_valid, o_pc_next, o_commit, o_commit_pc, o_halt
    );
endinterface

// File: rtl/wbu_commit.sv
// Write-back/commit stage: GPR write port, machine CSRs, next-PC resolution and IFU redirect, ebreak halt.
// Optional macro WBU_MCYCLE_EN adds a 64-bit mcycle counter at CSR 0xB00/0xB80.
module wbu_commit #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RST_PC      = XLEN'(32'h3000_0000),
    parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h0000_1800)
) (
    input  logic          clock,
    input  logic          reset,
    wbu_commit_if.slave   bus
);
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [XLEN-1:0] CAUSE_ECALL_M = XLEN'(11);

    typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_HALT} state_t;

    state_t          state;
    logic            ready_q, pc_valid_q, halt_q, rf_wen_q, commit_q;
    logic [3:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q, pc_next_q, commit_pc_q;
    logic [XLEN-1:0] mstatus, mtvec, mepc, mcause;
    logic [XLEN-1:0] pc_next_c, csr_rdata_c;
    logic            accept_c, csr_we_c;

    assign accept_c = (state == S_IDLE) && bus.i_valid;
    // ecall owns the CSR write port on its accept edge
    assign csr_we_c = accept_c && bus.i_csr_wen && !bus.i_ecall;

    // Next-PC priority: trap, trap return, taken control flow, sequential
    always_comb begin
        pc_next_c = bus.i_pc + XLEN'(4);
        if (bus.i_ecall)
            pc_next_c = mtvec;
        else if (bus.i_mret)
            pc_next_c = mepc;
        else if (bus.i_brch || bus.i_jal || bus.i_jalr)
            pc_next_c = bus.i_pc_next;
    end

    // Commit/redirect sequencer with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_REDIRECT;
            ready_q     <= 1'b0;
            pc_valid_q  <= 1'b1;
            pc_next_q   <= RST_PC;
            halt_q      <= 1'b0;
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= 4'd0;
            rf_wdata_q  <= '0;
            commit_q    <= 1'b0;
            commit_pc_q <= '0;
        end else begin
            rf_wen_q <= 1'b0;
            commit_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        rf_wen_q    <= bus.i_wen && (bus.i_rd_addr != 4'd0);
                        rf_waddr_q  <= bus.i_rd_addr;
                        rf_wdata_q  <= bus.i_res;
                        commit_q    <= 1'b1;
                        commit_pc_q <= bus.i_pc;
                        ready_q     <= 1'b0;
                        if (bus.i_ebreak) begin
                            state      <= S_HALT;
                            halt_q     <= 1'b1;
                            pc_valid_q <= 1'b0;
                        end else begin
                            state      <= S_REDIRECT;
                            pc_valid_q <= 1'b1;
                            pc_next_q  <= pc_next_c;
                        end
                    end
                end
                S_REDIRECT: begin
                    if (bus.i_pc_ready) begin
                        state      <= S_IDLE;
                        pc_valid_q <= 1'b0;
                        ready_q    <= 1'b1;
                    end
                end
                S_HALT: begin
                    ready_q    <= 1'b0;
                    pc_valid_q <= 1'b0;
                    halt_q     <= 1'b1;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    // Machine CSRs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mstatus <= MSTATUS_RST;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else if (accept_c && bus.i_ecall) begin
            mepc    <= bus.i_pc;
            mcause  <= CAUSE_ECALL_M;
        end else if (csr_we_c) begin
            case (bus.i_csr_addr)
                CSR_MSTATUS: mstatus <= bus.i_csr_wdata;
                CSR_MTVEC:   mtvec   <= bus.i_csr_wdata;
                CSR_MEPC:    mepc    <= bus.i_csr_wdata;
                CSR_MCAUSE:  mcause  <= bus.i_csr_wdata;
                default: ;
            endcase
        end
    end

`ifdef WBU_MCYCLE_EN
    logic [63:0] mcycle, mcycle_nxt_c;

    // Increment first, then let a CSR write override the addressed half
    always_comb begin
        mcycle_nxt_c = mcycle + 64'd1;
        if (csr_we_c && (bus.i_csr_addr == CSR_MCYCLE))
            mcycle_nxt_c[31:0] = 32'(bus.i_csr_wdata);
        if (csr_we_c && (bus.i_csr_addr == CSR_MCYCLEH))
            mcycle_nxt_c[63:32] = 32'(bus.i_csr_wdata);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) mcycle <= 64'd0;
        else       mcycle <= mcycle_nxt_c;
    end
`endif

    // CSR read port: current register values, no write forwarding
    always_comb begin
        csr_rdata_c = '0;
        case (bus.i_csr_raddr)
            CSR_MSTATUS: csr_rdata_c = mstatus;
            CSR_MTVEC:   csr_rdata_c = mtvec;
            CSR_MEPC:    csr_rdata_c = mepc;
            CSR_MCAUSE:  csr_rdata_c = mcause;
`ifdef WBU_MCYCLE_EN
            CSR_MCYCLE:  csr_rdata_c = XLEN'(mcycle[31:0]);
            CSR_MCYCLEH: csr_rdata_c = XLEN'(mcycle[63:32]);
`endif
            default:     csr_rdata_c = '0;
        endcase
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_pc_valid  = pc_valid_q;
    assign bus.o_pc_next   = pc_next_q;
    assign bus.o_halt      = halt_q;
    assign bus.o_rf_wen    = rf_wen_q;
    assign bus.o_rf_waddr  = rf_waddr_q;
    assign bus.o_rf_wdata  = rf_wdata_q;
    assign bus.o_commit    = commit_q;
    assign bus.o_commit_pc = commit_pc_q;
    assign bus.o_csr_rdata = csr_rdata_c;
endmodule

// File: doc/wbu_commit.md
Name: wbu_commit

Overview:
Write-back/commit stage and consumer of the EXU→WBU pipeline register's outputs. Accepts one executed instruction per handshake and writes the GPR file through a registered write port. Owns the machine CSRs (mstatus, mtvec, mepc, mcause), resolves the next PC (sequential, branch/jump, ecall trap, mret) and hands it to the IFU over a valid/ready redirect channel. Halts permanently on ebreak.

Parameters:
XLEN, 32, data/PC width
RST_PC, 32'h3000_0000, value of o_pc_next out of reset (first fetch)
MSTATUS_RST, 32'h0000_1800, mstatus reset value

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-high reset
i_valid  in  1  instruction present from EXU/WBU register (its o_next)
o_ready  out  1  WBU can accept; drives the register's i_post_ready
i_pc  in  XLEN  PC of committing instruction
i_pc_next  in  XLEN  branch/jump target from EXU
i_res  in  XLEN  GPR write data
i_rd_addr  in  4  GPR destination
i_wen  in  1  GPR write enable
i_csr_wen  in  1  CSR write enable
i_csr_addr  in  12  CSR write address
i_csr_wdata  in  XLEN  CSR write data
i_brch, i_jal, i_jalr, i_ecall, i_mret, i_ebreak  in  1 each  instruction class flags
i_csr_raddr  in  12  CSR read address (from EXU)
o_csr_rdata  out  XLEN  combinational CSR read data
o_rf_wen  out  1  GPR write strobe
o_rf_waddr  out  4  GPR write address
o_rf_wdata  out  XLEN  GPR write data
o_pc_valid  out  1  redirect PC valid to IFU
o_pc_next  out  XLEN  next fetch PC
i_pc_ready  in  1  IFU accepts redirect
o_commit  out  1  one-cycle commit pulse (difftest)
o_commit_pc  out  XLEN  PC of committed instruction
o_halt  out  1  ebreak reached

Behaviour:
- Reset (async, immediate): state=REDIRECT, o_pc_next=RST_PC, o_pc_valid=1, o_ready=0, o_rf_wen=0, o_rf_waddr=0, o_rf_wdata=0, o_commit=0, o_commit_pc=0, o_halt=0; mstatus=MSTATUS_RST, mtvec=mepc=mcause=0. Reset mid-operation discards any pending commit/redirect.
- States: IDLE (o_ready=1), REDIRECT (o_pc_valid=1, o_ready=0), HALT (o_ready=0, o_pc_valid=0, o_halt=1).
- IDLE, i_valid=1 → accept on that edge:
  - GPR: o_rf_wen=i_wen && (i_rd_addr!=0), registered, asserted exactly one cycle after accept, with o_rf_waddr/o_rf_wdata latched. rd=0 never written.
  - o_commit=1 for that same single cycle with o_commit_pc=i_pc.
  - CSR update on accept edge. Priority: ecall (mepc←i_pc, mcause←11) over csr_wen (addr 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause; other addresses ignored).
  - Next PC, priority: ecall→mtvec (pre-update value); mret→mepc (pre-update value); brch/jal/jalr→i_pc_next; else i_pc+4 modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
  - ebreak → HALT (no redirect, GPR write still performed); else → REDIRECT.
- REDIRECT: o_pc_next held stable while i_pc_ready=0; on o_pc_valid && i_pc_ready → IDLE next cycle, o_pc_valid=0. No new accept while in REDIRECT.
- HALT: exits only by reset; i_valid ignored.
- o_csr_rdata: combinational from current registers; unmapped address → 0; same-cycle write is not forwarded (old value returned).
- Throughput: at most one instruction per 2 cycles (accept, redirect handshake).

Optional Feature:
WBU_MCYCLE_EN: when defined, adds 64-bit mcycle counter incremented every cycle from reset value 0, readable at 0xB00 (low) / 0xB80 (high) and writable via csr_wen (write wins over increment in that cycle; low-word overflow carries into high). When undefined, 0xB00/0xB80 read 0 and writes are ignored.

Test Plan:
- Reset release, i_pc_ready=1 → o_pc_valid=1, o_pc_next=0x3000_0000 for one handshake, then o_ready=1.
- Accept addi: i_pc=0x3000_0000, i_wen=1, rd=5, i_res=0x1234 → next cycle o_rf_wen=1, waddr=5, wdata=0x1234, o_commit_pc=0x3000_0000; o_pc_next=0x3000_0004.
- Write rd=0 with i_wen=1 → o_rf_wen stays 0; o_commit still pulses.
- csrw mtvec=0x3000_0100, then ecall at pc 0x3000_0020 → o_pc_next=0x3000_0100, mepc reads 0x3000_0020, mcause=11; following mret → o_pc_next=0x3000_0020.
- jal with i_pc_next=0x3000_0200, i_pc_ready held 0 for 3 cycles → o_pc_next stable, o_ready=0 throughout, accept resumes after handshake.
- ebreak → o_halt=1 permanently, o_ready=0, later i_valid ignored; assert reset mid-HALT → all outputs return to reset values.
